key_debounce_sync: RTL
======================

// Module: key_debounce_sync
// PURPOSE
//   Conditions raw push-button inputs before the key PIO slave samples them.
//   Per key: 2-flop synchronizer, counter-based debounce, registered edge detect.
//   key_db drives the key PIO in_port directly, with the same polarity as the pins,
//   so existing software reads it unchanged. press/release pulses serve future IRQ/edge logic.
// PARAMETERS
//   WIDTH            2        number of independent keys
//   DEBOUNCE_CYCLES  500000   consecutive stable cycles required to accept a change (10 ms @ 50 MHz); must be >= 1
//   PRESSED_LEVEL    1'b0     raw pin level meaning "pressed" (board keys are active-low)
//   localparam CNT_W = $clog2(DEBOUNCE_CYCLES+1)
// PORTS
//   clk            in   1      system clock
//   reset_n        in   1      reset, asynchronous, active-low
//   key_raw        in   WIDTH  asynchronous key pins, unsynchronized
//   key_db         out  WIDTH  debounced level, same polarity as key_raw; to PIO in_port
//   press_pulse    out  WIDTH  1-cycle strobe when key_db[i] enters PRESSED_LEVEL
//   release_pulse  out  WIDTH  1-cycle strobe when key_db[i] leaves PRESSED_LEVEL
// BEHAVIOUR
//   - Reset (async assert, sync use on clk): sync1/sync2/stable per bit = ~PRESSED_LEVEL (released).
//     cnt = 0. key_db = {WIDTH{~PRESSED_LEVEL}}. press_pulse = release_pulse = 0.
//   - Reset does not generate pulses, on assertion or on release.
//   - Synchronizer: sync1[i] <= key_raw[i]; sync2[i] <= sync1[i]. Only sync2 is used downstream.
//   - Per-bit debounce. Bits are fully independent; each bit has its own cnt[i] of CNT_W bits.
//   - Logic applied at each clk edge:
//       if sync2 == stable: cnt <= 0
//       else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2; cnt <= 0
//       else: cnt <= cnt + 1
//   - Any return of sync2 to stable before acceptance clears cnt. A bounce restarts the full window.
//   - Counter never wraps. Maximum value is DEBOUNCE_CYCLES-1.
//   - key_db = stable (registered output, no combinational path from key_raw).
//   - Latency: key_raw change sampled at edge k, then held → key_db changes after edge k+1+DEBOUNCE_CYCLES.
//     This is DEBOUNCE_CYCLES+2 edges in total.
//   - DEBOUNCE_CYCLES=1: change is accepted on the first cycle of mismatch (latency 3 edges).
//   - Pulses are registered, asserted high for exactly one cycle.
//     They assert in the same cycle key_db takes its new value:
//       press_pulse[i]   = stable[i] changed to PRESSED_LEVEL at this edge
//       release_pulse[i] = stable[i] changed to ~PRESSED_LEVEL at this edge
//   - press_pulse[i] and release_pulse[i] are never high together.
//   - Different bits may pulse in the same cycle.
//   - Reset mid-count: state returns immediately to reset values and counting progress is lost.
//     If a key is still held after reset_n rises, the press is accepted DEBOUNCE_CYCLES+2 edges after the first sampling edge.
// TESTING (bench uses DEBOUNCE_CYCLES=4, WIDTH=2, PRESSED_LEVEL=0)
//   1 Reset with key_raw=2'b11, then release reset and run 20 cycles
//     -> key_db=2'b11; no pulse ever asserted.
//   2 key_raw 2'b11->2'b10 at edge k, then held
//     -> key_db=2'b10 after edge k+5; press_pulse=2'b01 for exactly that cycle; bit1 stays quiet.
//   3 Bounce: bit0 toggles every 2 cycles for 20 cycles, then held 0
//     -> key_db[0] stays 1 throughout the bounce; changes 6 edges after the final hold begins; exactly one press_pulse.
//   4 Both bits pressed at the same edge
//     -> both key_db bits fall on the same cycle; press_pulse=2'b11 for one cycle.
//     Then release both → release_pulse=2'b11 for one cycle, 6 edges after the release.
//   5 Bit0 held low; assert reset_n at cnt=2, then deassert with the key still low
//     -> key_db[0]=1 immediately on reset; press accepted 6 edges after the first post-reset sampling edge; one press_pulse.
//   6 One-cycle glitch on bit1 (1->0->1)
//     -> key_db unchanged; cnt[1] returns to 0; no pulses.

Source files
------------

// File: rtl/key_debounce_sync.sv
// Per-key push-button conditioning: 2-flop synchronizer, counter debounce and registered
// press/release strobes. key_db keeps the pin polarity so it can feed the key PIO directly.
module key_debounce_sync #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        PRESSED_LEVEL   = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_db,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] Released = {WIDTH{~PRESSED_LEVEL}};

  logic [WIDTH-1:0]            sync1_q, sync2_q;
  logic [WIDTH-1:0]            stable_q, stable_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            press_q, press_d;
  logic [WIDTH-1:0]            release_q, release_d;

  always_comb begin
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // Any agreement with the accepted level restarts the full window.
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      if (stable_d[i] != stable_q[i]) begin
        press_d[i]   = (stable_d[i] == PRESSED_LEVEL);
        release_d[i] = (stable_d[i] != PRESSED_LEVEL);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= Released;
      sync2_q   <= Released;
      stable_q  <= Released;
      cnt_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      sync1_q   <= key_raw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_db        = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule
